spi_controller: RTL and testbench

SPI initiator for the tape-in's SPI minion interface. It drives cs, sclk and mosi, samples miso, and exchanges one full-duplex packet per transaction. The block provides val/rdy send and receive streams to the host side. It is used in the FPGA/host harness and in the loopback test chip.

---
 rtl/spi_controller.sv | 92 +++++++++
 tb/tb_spi_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller: mode-0 SPI initiator exchanging one full-duplex packet per val/rdy transaction
module spi_controller #(
  parameter int BIT_WIDTH = 20,
  parameter int CLK_DIV   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         send_val,
  output logic                         send_rdy,
  input  logic [BIT_WIDTH-1:0]         send_msg,
  input  logic [$clog2(BIT_WIDTH):0]   packet_size,
  output logic                         recv_val,
  input  logic                         recv_rdy,
  output logic [BIT_WIDTH-1:0]         recv_msg,
  output logic                         cs,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso
);
  localparam int PW = $clog2(BIT_WIDTH) + 1;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, HIGH, LOW, STOP, DONE} state_t;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        bits, ps;
  logic [BIT_WIDTH-1:0] sh, sh_init;
  logic                 last;
  always_comb begin
    ps      = (packet_size == '0 || packet_size > PW'(BIT_WIDTH)) ? PW'(BIT_WIDTH) : packet_size;
    sh_init = send_msg << (PW'(BIT_WIDTH) - ps);
    last    = cnt == CW'(CLK_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bits     <= '0;
      sh       <= '0;
      send_rdy <= 1'b0;
      recv_val <= 1'b0;
      recv_msg <= '0;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == DONE || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          send_rdy <= 1'b1;
          cs       <= 1'b1;
          sclk     <= 1'b0;
          if (send_val && send_rdy) begin
            state    <= START;
            send_rdy <= 1'b0;
            bits     <= ps;
            sh       <= sh_init;
            recv_msg <= '0;
            cs       <= 1'b0;
            mosi     <= sh_init[BIT_WIDTH-1];
          end
        end
        START: if (last) begin
          state <= HIGH;
          sclk  <= 1'b1;
        end
        HIGH: if (last) begin
          state    <= LOW;
          sclk     <= 1'b0;
          recv_msg <= {recv_msg[BIT_WIDTH-2:0], miso};
          bits     <= bits - 1'b1;
          sh       <= sh << 1;
          mosi     <= sh[BIT_WIDTH-2];
        end
        LOW: if (last) begin
          state <= bits == '0 ? STOP : HIGH;
          cs    <= bits == '0;
          sclk  <= bits != '0;
        end
        STOP: if (last) begin
          state    <= DONE;
          recv_val <= 1'b1;
        end
        DONE: if (recv_rdy) begin
          state    <= IDLE;
          recv_val <= 1'b0;
          send_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed vectors against a minion model, plus clock-divider, backpressure and reset sequences
module tb_spi_controller;
  localparam int W  = 20;
  localparam int PW = $clog2(W) + 1;
  logic clk = 0, reset = 1, send_val = 0, send_val1 = 0, recv_rdy = 0, miso = 0, miso1 = 0;
  logic [W-1:0] send_msg = '0;
  logic [PW-1:0] packet_size = '0;
  logic send_rdy, recv_val, cs, sclk, mosi;
  logic send_rdy1, recv_val1, cs1, sclk1, mosi1;
  logic [W-1:0] recv_msg, recv_msg1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  spi_controller #(.BIT_WIDTH(W), .CLK_DIV(1)) dut (
    .clk(clk), .reset(reset), .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .packet_size(packet_size), .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso));

  spi_controller #(.BIT_WIDTH(W), .CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .send_val(send_val1), .send_rdy(send_rdy1), .send_msg(send_msg),
    .packet_size(packet_size), .recv_val(recv_val1), .recv_rdy(recv_rdy), .recv_msg(recv_msg1),
    .cs(cs1), .sclk(sclk1), .mosi(mosi1), .miso(miso1));

  // Minion: loads its MSB on cs fall, captures mosi on sclk rise, shifts miso on sclk fall
  logic loop = 1, pcs = 1, psclk = 0;
  int min_ps = 20, idx = -1;
  logic [W-1:0] min_tx = '0, min_rx = '0;
  always @(negedge clk) begin
    if (!cs && pcs) begin
      idx = min_ps - 1;
      min_rx = '0;
    end else if (!cs && sclk && !psclk) min_rx = {min_rx[W-2:0], mosi};
    else if (!cs && !sclk && psclk) idx--;
    if (loop) miso = mosi;
    else if (idx >= 0 && !cs) miso = min_tx[idx];
    else miso = 1'b0;
    miso1 = mosi1;
    pcs = cs;
    psclk = sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [PW-1:0] ps, input logic [W-1:0] msg,
                      output int lat, output int rises, output int cslow);
    int t;
    logic ps_s;
    t = 0;
    while (!send_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy_wait", send_rdy, 1);
    send_val = 1;
    packet_size = ps;
    send_msg = msg;
    @(posedge clk);
    #1 send_val = 0;
    lat = 0; rises = 0; cslow = 0; ps_s = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (!cs) cslow++;
      if (sclk && !ps_s) rises++;
      ps_s = sclk;
      if (recv_val) break;
    end
  endtask

  task automatic handshake();
    recv_rdy = 1;
    @(posedge clk);
    #1 recv_rdy = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [PW-1:0] ps;
    logic [W-1:0]  msg;
    logic          lp;
    logic [W-1:0]  tx;
    int            eps;
    logic [W-1:0]  exp_rx;
    logic [W-1:0]  exp_cap;
  } vec_t;
  vec_t v[8];

  initial begin
    int lat, rises, cslow, bad, t, first, prevr, run;
    logic ps_s;
    v[0] = '{PW'(20), 20'hA5C3F, 1'b1, 20'h00000, 20, 20'hA5C3F, 20'hA5C3F};
    v[1] = '{PW'(20), 20'hFFFFF, 1'b0, 20'h12345, 20, 20'h12345, 20'hFFFFF};
    v[2] = '{PW'(8),  20'hFFF3C, 1'b1, 20'h00000, 8,  20'h0003C, 20'h0003C};
    v[3] = '{PW'(0),  20'h12345, 1'b1, 20'h00000, 20, 20'h12345, 20'h12345};
    v[4] = '{PW'(25), 20'hABCDE, 1'b1, 20'h00000, 20, 20'hABCDE, 20'hABCDE};
    v[5] = '{PW'(1),  20'h00001, 1'b0, 20'h00000, 1,  20'h00000, 20'h00001};
    v[6] = '{PW'(4),  20'h00006, 1'b0, 20'h00009, 4,  20'h00009, 20'h00006};
    v[7] = '{PW'(3),  20'hFFFF5, 1'b0, 20'h00003, 3,  20'h00003, 20'h00005};

    repeat (2) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_send_rdy", send_rdy, 0);
    chk("rst_recv_val", recv_val, 0);
    chk("rst_recv_msg", recv_msg, 0);
    reset = 0;
    @(negedge clk);

    foreach (v[i]) begin
      loop = v[i].lp;
      min_tx = v[i].tx;
      min_ps = v[i].eps;
      xfer(v[i].ps, v[i].msg, lat, rises, cslow);
      chk($sformatf("v%0d_latency", i), lat, 2 * v[i].eps + 3);
      chk($sformatf("v%0d_rises", i), rises, v[i].eps);
      chk($sformatf("v%0d_cs_low", i), cslow, 2 * v[i].eps + 1);
      chk($sformatf("v%0d_recv_msg", i), recv_msg, v[i].exp_rx);
      chk($sformatf("v%0d_minion_cap", i), min_rx, v[i].exp_cap);
      handshake();
      chk($sformatf("v%0d_recv_val_drop", i), recv_val, 0);
      chk($sformatf("v%0d_send_rdy_back", i), send_rdy, 1);
    end

    // CLK_DIV=3: phase lengths and latency on the second instance
    t = 0;
    while (!send_rdy1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    send_val1 = 1;
    packet_size = 4;
    send_msg = 20'h9;
    @(posedge clk);
    #1 send_val1 = 0;
    lat = 0; rises = 0; cslow = 0; bad = 0; first = 0; prevr = 0; run = 0; ps_s = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (!cs1) cslow++;
      if (sclk1 && !ps_s) begin
        rises++;
        if (rises == 1) first = lat;
        else if (lat - prevr != 6) bad++;
        prevr = lat;
      end
      if (!sclk1 && ps_s && run != 3) bad++;
      run = sclk1 ? run + 1 : 0;
      ps_s = sclk1;
      if (recv_val1) break;
    end
    chk("div3_latency", lat, 31);
    chk("div3_rises", rises, 4);
    chk("div3_first_rise", first, 4);
    chk("div3_phase_len", bad, 0);
    chk("div3_cs_low", cslow, 27);
    chk("div3_recv_msg", recv_msg1, 20'h9);
    handshake();

    // Backpressure: result held stable while recv_rdy stays low
    loop = 1;
    min_ps = 20;
    xfer(20, 20'h5A5A5, lat, rises, cslow);
    chk("bp_latency", lat, 43);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!recv_val || recv_msg !== 20'h5A5A5 || send_rdy) bad++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_recv_msg", recv_msg, 20'h5A5A5);
    handshake();

    // Reset during the 5th HIGH phase
    t = 0;
    while (!send_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    send_val = 1;
    packet_size = 20;
    send_msg = 20'hC0FFE;
    @(posedge clk);
    #1 send_val = 0;
    rises = 0; ps_s = 0; t = 0;
    while (rises < 5 && t < 200) begin
      @(negedge clk);
      t++;
      if (sclk && !ps_s) rises++;
      ps_s = sclk;
    end
    chk("rst5_rise_reached", rises, 5);
    chk("rst5_in_high", sclk, 1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst5_cs", cs, 1);
    chk("rst5_sclk", sclk, 0);
    chk("rst5_recv_val", recv_val, 0);
    chk("rst5_recv_msg", recv_msg, 0);
    chk("rst5_send_rdy", send_rdy, 0);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst5_send_rdy_after", send_rdy, 1);
    chk("rst5_cs_after", cs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
